// File: rtl/pipelined_ks_subtractor.sv
// Pipelined Kogge-Stone subtractor: a + ~b + 1, one prefix level per stage.
// Valid/ready output with a global advance that stalls the whole pipe.
module pipelined_ks_subtractor #(
  parameter int PRECISION = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PRECISION-1:0] operand_a_i,
  input  logic [PRECISION-1:0] operand_b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PRECISION-1:0] result_o,
  output logic                 borrow_o,
  output logic                 overflow_o,
  output logic                 zero_o
);

  localparam int W = PRECISION;
  localparam int L = $clog2(PRECISION);

  logic advance;

  logic [L:0][W-1:0]   g_q, g_d;
  logic [L-1:0][W-1:0] p_q, p_d;
  logic [L:0][W-1:0]   po_q, po_d;
  logic [L:0]          sa_q, sa_d;
  logic [L:0]          sb_q, sb_d;
  logic [L:0]          v_q, v_d;

  logic [W-1:0] res_d;
  logic [W-1:0] result_q;
  logic         out_valid_q;
  logic         borrow_q;
  logic         ovf_q;
  logic         zero_q;

  assign advance    = ~out_valid_q | out_ready_i;
  assign in_ready_o = advance;

  // Level k combines spans of 2^(k-1); carry-in 1 lives in G[0].
  always_comb begin
    g_d  = '0;
    p_d  = '0;
    po_d = '0;
    sa_d = '0;
    sb_d = '0;
    v_d  = '0;
    p_d[0]    = operand_a_i ^ ~operand_b_i;
    g_d[0]    = operand_a_i & ~operand_b_i;
    g_d[0][0] = operand_a_i[0] | ~operand_b_i[0];
    po_d[0]   = operand_a_i ^ ~operand_b_i;
    sa_d[0]   = operand_a_i[W-1];
    sb_d[0]   = operand_b_i[W-1];
    v_d[0]    = in_valid_i;
    for (int k = 1; k <= L; k++) begin
      g_d[k]  = g_q[k-1];
      po_d[k] = po_q[k-1];
      sa_d[k] = sa_q[k-1];
      sb_d[k] = sb_q[k-1];
      v_d[k]  = v_q[k-1];
      for (int i = 1 << (k-1); i < W; i++) begin
        g_d[k][i] = g_q[k-1][i]
                  | (p_q[k-1][i] & g_q[k-1][i-(1 << (k-1))]);
      end
    end
    for (int k = 1; k < L; k++) begin
      p_d[k] = p_q[k-1];
      for (int i = 1 << (k-1); i < W; i++) begin
        p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-(1 << (k-1))];
      end
    end
  end

  always_comb begin
    res_d    = '0;
    res_d[0] = ~po_q[L][0];
    for (int i = 1; i < W; i++) begin
      res_d[i] = po_q[L][i] ^ g_q[L][i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (advance) begin
      g_q  <= g_d;
      p_q  <= p_d;
      po_q <= po_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      v_q         <= v_d;
      out_valid_q <= v_q[L];
      if (v_q[L]) begin
        result_q <= res_d;
        borrow_q <= ~g_q[L][W-1];
        ovf_q    <= (sa_q[L] != sb_q[L]) && (res_d[W-1] != sa_q[L]);
        zero_q   <= (res_d == '0);
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign borrow_o    = borrow_q;
  assign overflow_o  = ovf_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_pipelined_ks_subtractor.sv
// Bench for pipelined_ks_subtractor: directed vectors, stall, reset flush,
// and random traffic scored against an arithmetic reference queue.
module tb_pipelined_ks_subtractor;

  localparam int P = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct packed {
    logic [P-1:0] res;
    logic         borrow;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [P-1:0] a;
  logic [P-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] res;
  logic         borrow;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int passes = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  pipelined_ks_subtractor #(.PRECISION(P)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .operand_a_i (a),
    .operand_b_i (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (res),
    .borrow_o    (borrow),
    .overflow_o  (ovf),
    .zero_o      (zero)
  );

  function automatic exp_t model(input logic [P-1:0] x, input logic [P-1:0] y);
    exp_t   e;
    longint sd;
    e.res    = x - y;
    e.borrow = (x < y);
    sd       = longint'($signed(x)) - longint'($signed(y));
    e.ovf    = (sd > SMAX) || (sd < SMIN);
    e.zero   = (e.res == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_dir(input string tag, input logic [P-1:0] ta,
                         input logic [P-1:0] tb_, input logic [P-1:0] er,
                         input logic eb, input logic eo, input logic ez);
    a = ta;
    b = tb_;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 chk({tag, "_inrdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      chk($sformatf("%s_valid_e%0d", tag, n), 64'(out_valid), 64'(n == 6));
    end
    chk({tag, "_res"}, 64'(res), 64'(er));
    chk({tag, "_borrow"}, 64'(borrow), 64'(eb));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    chk({tag, "_zero"}, 64'(zero), 64'(ez));
    @(negedge clk);
  endtask

  initial begin
    int   sent;
    int   cyc;
    bit   seen;
    exp_t e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_borrow", 64'(borrow), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    rst_n = 1'b1;
    #1 chk("rst_inrdy", 64'(in_ready), 64'd1);
    @(negedge clk);

    run_dir("d5m3", 32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    run_dir("d3m5", 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    run_dir("dmin1", 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_dir("d0mmin", 32'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    run_dir("deq", 32'h1234, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1);
    run_dir("d00", 32'd0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1);

    a = 32'd5;
    b = 32'd3;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) begin
      a = $urandom;
      b = $urandom;
      @(negedge clk);
    end
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_res", 64'(res), 64'd2);
    chk("hold_inrdy", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1 chk("hold_release_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("hold_drained", 64'(out_valid), 64'd0);

    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (3) begin
      a = $urandom;
      b = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("flush_valid", 64'(out_valid), 64'd0);
    #1 chk("flush_inrdy", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_stale", 64'(seen), 64'd0);
    run_dir("post_rst", 32'h10, 32'h1, 32'hF, 1'b0, 1'b0, 1'b0);

    sent = 0;
    cyc  = 0;
    while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 8);
      a         = $urandom;
      b         = $urandom;
      if ($urandom_range(0, 15) == 0) b = a;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      chk("rnd_inrdy", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("rnd_res", 64'(res), 64'(e.res));
          chk("rnd_flags", 64'({borrow, ovf, zero}),
              64'({e.borrow, e.ovf, e.zero}));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_timeout", 64'(cyc < 20000), 64'd1);
    chk("rnd_sent", 64'(sent), 64'd1000);
    chk("rnd_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
